// File: rtl/br_resolve_unit.sv
// LC-3 BR resolver: latches CC flags and IR at Start, then produces BEN, the branch target and LD_PC/Done pulses.
// Optional BR_STATS_EN macro adds saturating taken / not-taken counters.
module br_resolve_unit #(
    parameter int          ADDR_W    = 16,
    parameter int          OFFS_W    = 9,
    parameter logic [3:0]  BR_OPCODE = 4'b0000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [15:0]       IR,
    input  logic [ADDR_W-1:0] PC,
    input  logic              Nin,
    input  logic              Zin,
    input  logic              Pin,
    output logic              Busy,
    output logic              BEN,
    output logic              LD_PC,
    output logic [ADDR_W-1:0] PC_target,
    output logic              Done
`ifdef BR_STATS_EN
    ,
    output logic [15:0]       Taken_Cnt,
    output logic [15:0]       NotTaken_Cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;

    logic        [3:0]        op_p0;
    logic        [2:0]        nzp_p0;
    logic signed [OFFS_W-1:0] off_p0;
    logic        [ADDR_W-1:0] pc_p0;
    logic        [2:0]        cc_p0;

    logic                     ben_c;
    logic        [ADDR_W-1:0] target_c;

    function automatic logic signed [ADDR_W-1:0] sext_off(input logic signed [OFFS_W-1:0] off);
        logic signed [ADDR_W-1:0] ext;
        ext = {{(ADDR_W-OFFS_W){off[OFFS_W-1]}}, off};
        return ext;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // Stage p0: operand capture on an accepted Start; later IR/CC changes are invisible
    always_ff @(posedge Clk) begin
        if (state == IDLE && Start) begin
            op_p0  <= IR[15:12];
            nzp_p0 <= IR[11:9];
            off_p0 <= IR[OFFS_W-1:0];
            pc_p0  <= PC;
            cc_p0  <= {Nin, Zin, Pin};
        end
    end

    // Wrap-around of the target is intentional: the address space is modular
    always_comb begin
        ben_c    = (op_p0 == BR_OPCODE) && |(nzp_p0 & cc_p0);
        target_c = pc_p0 + $unsigned(sext_off(off_p0));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            BEN       <= 1'b0;
            LD_PC     <= 1'b0;
            Done      <= 1'b0;
            PC_target <= '0;
        end else begin
            LD_PC <= 1'b0;
            Done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= EVAL;
                        Busy  <= 1'b1;
                    end
                end
                EVAL: begin
                    BEN       <= ben_c;
                    PC_target <= target_c;
                    if (ben_c) begin
                        state <= LOAD;
                        LD_PC <= 1'b1;
                    end else begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= DONE;
                    Done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BR_STATS_EN
    // BEN is already final while in DONE, so it selects which counter advances
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Taken_Cnt    <= '0;
            NotTaken_Cnt <= '0;
        end else if (state == DONE) begin
            if (BEN) Taken_Cnt    <= sat_inc(Taken_Cnt);
            else     NotTaken_Cnt <= sat_inc(NotTaken_Cnt);
        end
    end
`endif

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed table-driven bench for br_resolve_unit, plus hand sequences for restart and reset corners.
module tb_br_resolve_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] IR = '0;
    logic [15:0] PC = '0;
    logic        Nin = 1'b0, Zin = 1'b0, Pin = 1'b0;
    logic        Busy, BEN, LD_PC, Done;
    logic [15:0] PC_target;
`ifdef BR_STATS_EN
    logic [15:0] Taken_Cnt, NotTaken_Cnt;
`endif

    int errors = 0;
    int checks = 0;

    br_resolve_unit dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .IR        (IR),
        .PC        (PC),
        .Nin       (Nin),
        .Zin       (Zin),
        .Pin       (Pin),
        .Busy      (Busy),
        .BEN       (BEN),
        .LD_PC     (LD_PC),
        .PC_target (PC_target),
        .Done      (Done)
`ifdef BR_STATS_EN
        ,
        .Taken_Cnt    (Taken_Cnt),
        .NotTaken_Cnt (NotTaken_Cnt)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [2:0]  cc;
        logic        ben;
        logic [15:0] tgt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge of the first IDLE cycle after Done
    task automatic run_op(input int id, input logic [15:0] pc, input logic [15:0] ir,
                          input logic [2:0] cc, input logic ben, input logic [15:0] tgt);
        PC = pc; IR = ir; {Nin, Zin, Pin} = cc; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk($sformatf("op%0d_busy_eval", id), Busy, 1);
        chk($sformatf("op%0d_ldpc_eval", id), LD_PC, 0);
        chk($sformatf("op%0d_done_eval", id), Done, 0);
        @(negedge Clk);
        chk($sformatf("op%0d_ben", id), BEN, ben);
        chk($sformatf("op%0d_target", id), PC_target, tgt);
        chk($sformatf("op%0d_ldpc_c2", id), LD_PC, ben);
        chk($sformatf("op%0d_done_c2", id), Done, !ben);
        if (ben) begin
            @(negedge Clk);
            chk($sformatf("op%0d_ldpc_c3", id), LD_PC, 0);
            chk($sformatf("op%0d_done_c3", id), Done, 1);
        end
        @(negedge Clk);
        chk($sformatf("op%0d_busy_idle", id), Busy, 0);
        chk($sformatf("op%0d_done_idle", id), Done, 0);
        chk($sformatf("op%0d_ldpc_idle", id), LD_PC, 0);
        chk($sformatf("op%0d_ben_hold", id), BEN, ben);
        chk($sformatf("op%0d_tgt_hold", id), PC_target, tgt);
    endtask

    initial begin
        //            pc        ir        {N,Z,P}  ben   target
        vecs[0] = '{16'h3001, 16'h0E05, 3'b010, 1'b1, 16'h3006};  // BRnzp +5, Z
        vecs[1] = '{16'h3001, 16'h0805, 3'b001, 1'b0, 16'h3006};  // BRn, P
        vecs[2] = '{16'h3001, 16'h1E05, 3'b100, 1'b0, 16'h3006};  // ADD opcode
        vecs[3] = '{16'h0000, 16'h05FF, 3'b010, 1'b1, 16'hFFFF};  // BRz -1 wraps down
        vecs[4] = '{16'hFFFF, 16'h0201, 3'b001, 1'b1, 16'h0000};  // BRp +1 wraps up
        vecs[5] = '{16'h4000, 16'h0005, 3'b111, 1'b0, 16'h4005};  // nzp=000
        vecs[6] = '{16'h1000, 16'h0E10, 3'b000, 1'b0, 16'h1010};  // flags all zero
        vecs[7] = '{16'h3000, 16'h0F00, 3'b100, 1'b1, 16'h2F00};  // off=-256
        vecs[8] = '{16'h2000, 16'h0A02, 3'b110, 1'b1, 16'h2002};  // multiple flags, match
        vecs[9] = '{16'h2000, 16'h0402, 3'b101, 1'b0, 16'h2002};  // multiple flags, no match

        repeat (2) @(negedge Clk);
        chk("rst_busy", Busy, 0);
        chk("rst_ben", BEN, 0);
        chk("rst_ldpc", LD_PC, 0);
        chk("rst_done", Done, 0);
        chk("rst_target", PC_target, 16'h0000);
`ifdef BR_STATS_EN
        chk("rst_taken_cnt", Taken_Cnt, 0);
        chk("rst_nt_cnt", NotTaken_Cnt, 0);
`endif
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 10; i++) begin
            run_op(i, vecs[i].pc, vecs[i].ir, vecs[i].cc, vecs[i].ben, vecs[i].tgt);
`ifdef BR_STATS_EN
            if (i == 2) begin
                chk("stats_taken", Taken_Cnt, 1);
                chk("stats_not_taken", NotTaken_Cnt, 2);
            end
`endif
        end

        // Restart attempts in EVAL and LOAD, with CC/IR changed after the Start edge
        PC = 16'h3001; IR = 16'h0205; {Nin, Zin, Pin} = 3'b001; Start = 1'b1;
        @(negedge Clk);
        IR = 16'h0805; Nin = 1'b1; Pin = 1'b0;
        @(negedge Clk);
        chk("rs_ldpc", LD_PC, 1);
        chk("rs_ben", BEN, 1);
        chk("rs_target", PC_target, 16'h3006);
        @(negedge Clk);
        Start = 1'b0;
        chk("rs_done", Done, 1);
        @(negedge Clk);
        chk("rs_busy_idle", Busy, 0);
        @(negedge Clk);
        chk("rs_no_second_busy", Busy, 0);
        chk("rs_no_second_done", Done, 0);

        // Reset in the LOAD cycle aborts without a Done pulse
        PC = 16'h3001; IR = 16'h0E05; {Nin, Zin, Pin} = 3'b010; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        chk("ab_ldpc", LD_PC, 1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("ab_busy", Busy, 0);
        chk("ab_ben", BEN, 0);
        chk("ab_ldpc_after", LD_PC, 0);
        chk("ab_done", Done, 0);
        chk("ab_target", PC_target, 16'h0000);
`ifdef BR_STATS_EN
        chk("ab_taken_cnt", Taken_Cnt, 0);
        chk("ab_nt_cnt", NotTaken_Cnt, 0);
`endif
        Reset = 1'b0;
        run_op(20, 16'h3001, 16'h0805, 3'b001, 1'b0, 16'h3006);
`ifdef BR_STATS_EN
        chk("ab_nt_after", NotTaken_Cnt, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
